// File: rtl/mw_cook_controller.sv
`default_nettype none
// ============================================================================
//  Module   : mw_cook_controller
//  Purpose  : Control FSM for the microwave cook cycle. Shifts keypad digits
//             into the external minutes/seconds countdown timer, produces a
//             one-second count-enable strobe while cooking, reacts to the
//             timer zero flag and drives the magnetron and status outputs.
//
//  Parameters
//    CLK_DIV     clock cycles per one-second tick (2 .. 2**26)
//    DONE_SECS   seconds the DONE state is held before IDLE (1 .. 15)
//
//  Ports
//    clock        in   system clock, rising edge
//    Cn           in   asynchronous active-low reset
//    key_valid    in   one-cycle strobe, keypad digit present
//    key_digit    in   [3:0] BCD digit, 10..15 ignored
//    start        in   one-cycle strobe, start / resume cooking
//    stop         in   one-cycle strobe, pause, or clear when paused/idle
//    door_closed  in   level, 1 = door closed
//    zero         in   level from timer, 1 = all digits zero
//    tmr_in       out  [3:0] digit presented to the timer load input
//    tmr_load     out  one-cycle timer load strobe
//    tmr_clr_n    out  one-cycle active-low timer clear
//    tmr_en       out  one-cycle count enable, once per second in COOK
//    mag_on       out  magnetron enable
//    cooking      out  status, FSM in COOK
//    done         out  status, FSM in DONE
//    beep         out  (only with MW_BEEP_EN) toggles every second in DONE
//
//  Build option
//    MW_BEEP_EN   when defined, adds the beep output.
//
//  Revision : 1.0  initial release
// ============================================================================
module mw_cook_controller #(
  parameter int CLK_DIV   = 50000000,
  parameter int DONE_SECS = 3
) (
  input  logic       clock,
  input  logic       Cn,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop,
  input  logic       door_closed,
  input  logic       zero,
  output logic [3:0] tmr_in,
  output logic       tmr_load,
  output logic       tmr_clr_n,
  output logic       tmr_en,
  output logic       mag_on,
  output logic       cooking,
  output logic       done
`ifdef MW_BEEP_EN
  ,
  output logic       beep
`endif
);

  localparam int              TICK_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [3:0]      DONE_LAST = 4'(DONE_SECS - 1);
  localparam logic [1:0]      DIGITS_MAX = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_COOK  = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [TICK_W-1:0]   tick_cnt;
  logic [TICK_W-1:0]   tick_nxt;
  logic [1:0]          digit_cnt;
  logic [1:0]          digit_nxt;
  logic [3:0]          done_cnt;
  logic [3:0]          done_nxt;
  // Set by reset; forces the timer-clear pulse in the first cycle after release.
  logic                init_clr;

  logic [3:0]          tmr_in_nxt;
  logic                load_nxt;
  logic                clr_n_nxt;
  logic                en_nxt;

  logic                key_ok;
  logic                tick_last;

  assign key_ok    = key_valid && (key_digit <= 4'd9);
  assign tick_last = (tick_cnt == TICK_LAST);

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge Cn) begin
    if (!Cn) begin
      state     <= S_IDLE;
      tick_cnt  <= '0;
      digit_cnt <= '0;
      done_cnt  <= '0;
      init_clr  <= 1'b1;
      tmr_in    <= '0;
      tmr_load  <= 1'b0;
      tmr_clr_n <= 1'b1;
      tmr_en    <= 1'b0;
      mag_on    <= 1'b0;
      cooking   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      tick_cnt  <= tick_nxt;
      digit_cnt <= digit_nxt;
      done_cnt  <= done_nxt;
      init_clr  <= 1'b0;
      tmr_in    <= tmr_in_nxt;
      tmr_load  <= load_nxt;
      tmr_clr_n <= clr_n_nxt;
      tmr_en    <= en_nxt;
      // Status outputs are decoded from the next state so they are registered
      // and change on the same edge as the state itself.
      mag_on    <= (state_nxt == S_COOK);
      cooking   <= (state_nxt == S_COOK);
      done      <= (state_nxt == S_DONE);
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and next-output logic
  // Event priority inside each state: door open, stop, zero, start, key.
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    tick_nxt   = tick_cnt;
    digit_nxt  = digit_cnt;
    done_nxt   = done_cnt;
    tmr_in_nxt = tmr_in;
    load_nxt   = 1'b0;
    clr_n_nxt  = 1'b1;
    en_nxt     = 1'b0;

    if (init_clr) begin
      // Power-on clear of the timer; inputs are not acted on in this cycle so
      // the clear can never coincide with a load.
      clr_n_nxt = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (stop) begin
            clr_n_nxt = 1'b0;
            digit_nxt = '0;
          end else if (start && door_closed && !zero) begin
            state_nxt = S_COOK;
            tick_nxt  = '0;
          end else if (key_ok) begin
            tmr_in_nxt = key_digit;
            load_nxt   = 1'b1;
            digit_nxt  = 2'd1;
            state_nxt  = S_ENTRY;
          end
        end

        S_ENTRY: begin
          if (stop) begin
            clr_n_nxt = 1'b0;
            digit_nxt = '0;
            state_nxt = S_IDLE;
          end else if (start && door_closed && !zero) begin
            state_nxt = S_COOK;
            tick_nxt  = '0;
          end else if (key_ok && (digit_cnt != DIGITS_MAX)) begin
            tmr_in_nxt = key_digit;
            load_nxt   = 1'b1;
            digit_nxt  = digit_cnt + 2'd1;
          end
        end

        S_COOK: begin
          if (!door_closed || stop) begin
            // Tick count is frozen so a resume continues the partial second.
            state_nxt = S_PAUSE;
          end else if (zero && !tmr_en) begin
            // While tmr_en is high the timer is mid-decrement and zero is stale.
            state_nxt = S_DONE;
            tick_nxt  = '0;
            done_nxt  = '0;
          end else if (tick_last) begin
            tick_nxt = '0;
            en_nxt   = 1'b1;
          end else begin
            tick_nxt = tick_cnt + TICK_ONE;
          end
        end

        S_PAUSE: begin
          if (stop) begin
            clr_n_nxt = 1'b0;
            digit_nxt = '0;
            state_nxt = S_IDLE;
          end else if (start && door_closed) begin
            state_nxt = S_COOK;
          end
        end

        S_DONE: begin
          if (stop || start) begin
            state_nxt = S_IDLE;
          end else if (key_ok) begin
            tmr_in_nxt = key_digit;
            load_nxt   = 1'b1;
            digit_nxt  = 2'd1;
            state_nxt  = S_ENTRY;
          end else if (tick_last) begin
            tick_nxt = '0;
            if (done_cnt == DONE_LAST) begin
              state_nxt = S_IDLE;
            end else begin
              done_nxt = done_cnt + 4'd1;
            end
          end else begin
            tick_nxt = tick_cnt + TICK_ONE;
          end
        end

        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

`ifdef MW_BEEP_EN
  // --------------------------------------------------------------------------
  // Beeper: high on DONE entry, toggles on each one-second tick inside DONE,
  // low everywhere else.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge Cn) begin
    if (!Cn) begin
      beep <= 1'b0;
    end else if (state_nxt == S_DONE) begin
      if (state != S_DONE) begin
        beep <= 1'b1;
      end else if (tick_last) begin
        beep <= ~beep;
      end
    end else begin
      beep <= 1'b0;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mw_cook_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mw_cook_controller
//  Purpose  : Self-checking bench for mw_cook_controller with CLK_DIV=4 and
//             DONE_SECS=3. Expected behaviour comes from a time-based model:
//             one count-enable per CLK_DIV cycles of accumulated cooking,
//             a three-digit entry limit and a DONE_SECS*CLK_DIV done window.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mw_cook_controller;

  localparam int CLK_DIV   = 4;
  localparam int DONE_SECS = 3;
  localparam int DONE_CYC  = CLK_DIV * DONE_SECS;

  logic       clock       = 1'b0;
  logic       Cn          = 1'b0;
  logic       key_valid   = 1'b0;
  logic [3:0] key_digit   = 4'd0;
  logic       start       = 1'b0;
  logic       stop        = 1'b0;
  logic       door_closed = 1'b1;
  logic       zero        = 1'b1;
  logic [3:0] tmr_in;
  logic       tmr_load;
  logic       tmr_clr_n;
  logic       tmr_en;
  logic       mag_on;
  logic       cooking;
  logic       done;
`ifdef MW_BEEP_EN
  logic       beep;
`endif

  int n_tests    = 0;
  int n_fail     = 0;
  // Cycles actually spent cooking since the last start from ENTRY/IDLE.
  int cook_edges = 0;

  mw_cook_controller #(
    .CLK_DIV  (CLK_DIV),
    .DONE_SECS(DONE_SECS)
  ) dut (
    .clock      (clock),
    .Cn         (Cn),
    .key_valid  (key_valid),
    .key_digit  (key_digit),
    .start      (start),
    .stop       (stop),
    .door_closed(door_closed),
    .zero       (zero),
    .tmr_in     (tmr_in),
    .tmr_load   (tmr_load),
    .tmr_clr_n  (tmr_clr_n),
    .tmr_en     (tmr_en),
    .mag_on     (mag_on),
    .cooking    (cooking),
    .done       (done)
`ifdef MW_BEEP_EN
    ,
    .beep       (beep)
`endif
  );

  always #5 clock = ~clock;

  // A second has elapsed whenever accumulated cooking time hits a multiple of CLK_DIV.
  function automatic logic exp_en();
    return (cook_edges > 0) && ((cook_edges % CLK_DIV) == 0);
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_strobes();
    key_valid = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
  endtask

  task automatic test_reset();
    Cn = 1'b0; door_closed = 1'b1; zero = 1'b1; clear_strobes();
    repeat (2) cyc();
    n_tests++;
    if ({tmr_load, tmr_en, mag_on, cooking, done} !== 5'b0 || tmr_in !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: load/en/mag/cook/done=%b tmr_in=%0d, expected 00000 and 0",
               {tmr_load, tmr_en, mag_on, cooking, done}, tmr_in);
    end
    n_tests++;
    if (tmr_clr_n !== 1'b1) begin
      n_fail++; $display("FAIL reset_clr_n: got %b expected 1", tmr_clr_n);
    end
`ifdef MW_BEEP_EN
    n_tests++;
    if (beep !== 1'b0) begin
      n_fail++; $display("FAIL reset_beep: got %b expected 0", beep);
    end
`endif
    Cn = 1'b1;
    cyc();
    n_tests++;
    if (tmr_clr_n !== 1'b0) begin
      n_fail++; $display("FAIL init_clear_pulse: got %b expected 0", tmr_clr_n);
    end
    cyc();
    n_tests++;
    if (tmr_clr_n !== 1'b1) begin
      n_fail++; $display("FAIL init_clear_end: got %b expected 1", tmr_clr_n);
    end
  endtask

  task automatic test_entry();
    int n, acc, d;
    logic exp_load;
    for (int s = 0; s < 3; s++) begin
      acc = 0;
      n = (s == 0) ? 3 : ((s == 1) ? 4 : 6);
      for (int i = 0; i < n; i++) begin
        case (s)
          0:       d = (i == 0) ? 1 : ((i == 1) ? 3 : 0);
          1:       d = i + 1;
          default: d = int'($urandom_range(0, 15));
        endcase
        key_valid = 1'b1; key_digit = 4'(d);
        cyc(); clear_strobes();
        exp_load = (d <= 9) && (acc < 3);
        n_tests++;
        if (tmr_load !== exp_load || (exp_load && tmr_in !== 4'(d)) || tmr_clr_n !== 1'b1) begin
          n_fail++;
          $display("FAIL entry_load s%0d key%0d digit=%0d: load=%b tmr_in=%0d clr_n=%b, expected load=%b tmr_in=%0d clr_n=1",
                   s, i, d, tmr_load, tmr_in, tmr_clr_n, exp_load, d);
        end
        if (exp_load) acc++;
        cyc();
        n_tests++;
        if (tmr_load !== 1'b0) begin
          n_fail++; $display("FAIL entry_load_width s%0d key%0d: load=%b expected 0", s, i, tmr_load);
        end
        repeat ($urandom_range(0, 2)) cyc();
      end
      stop = 1'b1; cyc(); clear_strobes();
      n_tests++;
      if (tmr_clr_n !== 1'b0 || tmr_load !== 1'b0 || cooking !== 1'b0) begin
        n_fail++;
        $display("FAIL entry_stop_clear s%0d: clr_n=%b load=%b cooking=%b, expected 0 0 0", s, tmr_clr_n, tmr_load, cooking);
      end
      cyc();
      n_tests++;
      if (tmr_clr_n !== 1'b1) begin
        n_fail++; $display("FAIL entry_stop_clear_end s%0d: clr_n=%b expected 1", s, tmr_clr_n);
      end
    end
  endtask

  task automatic test_cook_done(input bit zero_on_tick);
    int run;
    logic exp_beep;
    key_valid = 1'b1; key_digit = 4'($urandom_range(1, 9)); cyc(); clear_strobes();
    zero = 1'b0; door_closed = 1'b1;
    start = 1'b1; cyc(); clear_strobes();
    cook_edges = 0;
    n_tests++;
    if ({mag_on, cooking, done, tmr_en} !== 4'b1100) begin
      n_fail++; $display("FAIL cook_entry: mag/cook/done/en=%b expected 1100", {mag_on, cooking, done, tmr_en});
    end
    run = CLK_DIV * int'($urandom_range(1, 3)) + int'($urandom_range(0, CLK_DIV - 1));
    for (int k = 0; k < run; k++) begin
      cyc(); cook_edges++;
      n_tests++;
      if ({tmr_en, mag_on, cooking} !== {exp_en(), 2'b11}) begin
        n_fail++;
        $display("FAIL cook_tick cycle%0d: en/mag/cook=%b expected %b11", cook_edges, {tmr_en, mag_on, cooking}, exp_en());
      end
    end
    // Line the zero flag up with the wanted tmr_en phase.
    for (int k = 0; k < CLK_DIV && (exp_en() != zero_on_tick); k++) begin
      cyc(); cook_edges++;
      n_tests++;
      if (tmr_en !== exp_en()) begin
        n_fail++; $display("FAIL cook_align cycle%0d: en=%b expected %b", cook_edges, tmr_en, exp_en());
      end
    end
    zero = 1'b1;
    if (zero_on_tick) begin
      // Zero seen on a tmr_en cycle is ignored for one cycle.
      cyc(); cook_edges++;
      n_tests++;
      if ({done, cooking, tmr_en} !== {2'b01, exp_en()}) begin
        n_fail++; $display("FAIL zero_during_tick: done/cook/en=%b expected 01%b", {done, cooking, tmr_en}, exp_en());
      end
    end
    cyc();
    n_tests++;
    if ({done, mag_on, cooking, tmr_en} !== 4'b1000) begin
      n_fail++; $display("FAIL done_entry: done/mag/cook/en=%b expected 1000", {done, mag_on, cooking, tmr_en});
    end
`ifdef MW_BEEP_EN
    n_tests++;
    if (beep !== 1'b1) begin
      n_fail++; $display("FAIL beep_start: got %b expected 1", beep);
    end
`endif
    for (int k = 1; k <= DONE_CYC; k++) begin
      cyc();
      n_tests++;
      if ({done, tmr_en} !== {(k < DONE_CYC), 1'b0}) begin
        n_fail++; $display("FAIL done_hold cycle%0d: done/en=%b expected %b0", k, {done, tmr_en}, (k < DONE_CYC));
      end
`ifdef MW_BEEP_EN
      exp_beep = (k < DONE_CYC) && (((k / CLK_DIV) % 2) == 0);
      n_tests++;
      if (beep !== exp_beep) begin
        n_fail++; $display("FAIL beep_pattern cycle%0d: got %b expected %b", k, beep, exp_beep);
      end
`endif
    end
  endtask

  task automatic test_pause(input int hold);
    int first_en;
    key_valid = 1'b1; key_digit = 4'($urandom_range(1, 9)); cyc(); clear_strobes();
    zero = 1'b0; door_closed = 1'b1;
    start = 1'b1; cyc(); clear_strobes();
    cook_edges = 0;
    for (int k = 0; k < 2 * CLK_DIV && (cook_edges < CLK_DIV || (cook_edges % CLK_DIV) != hold); k++) begin
      cyc(); cook_edges++;
      n_tests++;
      if ({tmr_en, mag_on} !== {exp_en(), 1'b1}) begin
        n_fail++; $display("FAIL pause_precook cycle%0d: en/mag=%b expected %b1", cook_edges, {tmr_en, mag_on}, exp_en());
      end
    end
    door_closed = 1'b0;
    cyc();
    n_tests++;
    if ({mag_on, cooking, tmr_en} !== 3'b000) begin
      n_fail++; $display("FAIL door_open_pause hold%0d: mag/cook/en=%b expected 000", hold, {mag_on, cooking, tmr_en});
    end
    start = 1'b1; cyc(); clear_strobes();
    n_tests++;
    if (mag_on !== 1'b0) begin
      n_fail++; $display("FAIL start_door_open: mag=%b expected 0", mag_on);
    end
    repeat ($urandom_range(1, 5)) begin
      cyc();
      n_tests++;
      if ({mag_on, tmr_en} !== 2'b00) begin
        n_fail++; $display("FAIL pause_hold: mag/en=%b expected 00", {mag_on, tmr_en});
      end
    end
    door_closed = 1'b1; start = 1'b1; cyc(); clear_strobes();
    n_tests++;
    if ({mag_on, cooking, tmr_en} !== 3'b110) begin
      n_fail++; $display("FAIL resume: mag/cook/en=%b expected 110", {mag_on, cooking, tmr_en});
    end
    first_en = 0;
    for (int k = 1; k <= CLK_DIV + 1; k++) begin
      cyc(); cook_edges++;
      if (tmr_en === 1'b1 && first_en == 0) first_en = k;
      n_tests++;
      if (tmr_en !== exp_en()) begin
        n_fail++; $display("FAIL resume_tick k%0d: en=%b expected %b", k, tmr_en, exp_en());
      end
    end
    n_tests++;
    if (first_en != CLK_DIV - hold) begin
      n_fail++; $display("FAIL resume_first_tick hold%0d: got %0d cycles expected %0d", hold, first_en, CLK_DIV - hold);
    end
    // Stop and start together: stop wins, so COOK pauses.
    stop = 1'b1; start = 1'b1; cyc(); clear_strobes();
    n_tests++;
    if ({mag_on, cooking, tmr_clr_n} !== 3'b001) begin
      n_fail++; $display("FAIL stop_start_same_cycle: mag/cook/clr_n=%b expected 001", {mag_on, cooking, tmr_clr_n});
    end
    stop = 1'b1; cyc(); clear_strobes();
    n_tests++;
    if ({tmr_clr_n, tmr_load, tmr_en, mag_on} !== 4'b0000) begin
      n_fail++; $display("FAIL pause_stop_clear: clr_n/load/en/mag=%b expected 0000", {tmr_clr_n, tmr_load, tmr_en, mag_on});
    end
    cyc();
    n_tests++;
    if (tmr_clr_n !== 1'b1) begin
      n_fail++; $display("FAIL pause_stop_clear_end: clr_n=%b expected 1", tmr_clr_n);
    end
    zero = 1'b1;
    key_valid = 1'b1; key_digit = 4'd7; cyc(); clear_strobes();
    n_tests++;
    if (tmr_load !== 1'b1 || tmr_in !== 4'd7) begin
      n_fail++; $display("FAIL idle_after_clear: load=%b tmr_in=%0d expected 1 and 7", tmr_load, tmr_in);
    end
    stop = 1'b1; cyc(); clear_strobes(); cyc();
  endtask

  task automatic test_done_exit();
    int a;
    logic [3:0] kd;
    for (int i = 0; i < 3; i++) begin
      a = i;
      key_valid = 1'b1; key_digit = 4'($urandom_range(1, 9)); cyc(); clear_strobes();
      zero = 1'b0; door_closed = 1'b1;
      start = 1'b1; cyc(); clear_strobes();
      repeat ($urandom_range(1, 6)) cyc();
      zero = 1'b1;
      repeat (2) cyc();
      n_tests++;
      if (done !== 1'b1) begin
        n_fail++; $display("FAIL done_reached i%0d: done=%b expected 1", i, done);
      end
      repeat ($urandom_range(0, 8)) cyc();
      kd = 4'($urandom_range(0, 9));
      case (a)
        0:       start = 1'b1;
        1:       stop = 1'b1;
        default: begin key_valid = 1'b1; key_digit = kd; end
      endcase
      cyc(); clear_strobes();
      n_tests++;
      if (done !== 1'b0 || tmr_load !== (a == 2) || (a == 2 && tmr_in !== kd)) begin
        n_fail++;
        $display("FAIL done_exit action%0d: done=%b load=%b tmr_in=%0d expected done=0 load=%b tmr_in=%0d",
                 a, done, tmr_load, tmr_in, (a == 2), kd);
      end
`ifdef MW_BEEP_EN
      n_tests++;
      if (beep !== 1'b0) begin
        n_fail++; $display("FAIL beep_exit action%0d: got %b expected 0", a, beep);
      end
`endif
      if (a == 2) begin
        stop = 1'b1; cyc(); clear_strobes(); cyc();
      end
    end
    // start with the timer at zero does nothing in IDLE
    start = 1'b1; cyc(); clear_strobes();
    n_tests++;
    if ({mag_on, cooking} !== 2'b00) begin
      n_fail++; $display("FAIL idle_start_zero: mag/cook=%b expected 00", {mag_on, cooking});
    end
  endtask

  task automatic test_async_reset();
    key_valid = 1'b1; key_digit = 4'd5; cyc(); clear_strobes();
    zero = 1'b0; door_closed = 1'b1;
    start = 1'b1; cyc(); clear_strobes();
    cook_edges = 0;
    for (int k = 0; k < CLK_DIV + 1 && !exp_en(); k++) begin
      cyc(); cook_edges++;
    end
    n_tests++;
    if ({tmr_en, mag_on} !== 2'b11) begin
      n_fail++; $display("FAIL pre_reset_tick: en/mag=%b expected 11", {tmr_en, mag_on});
    end
    #2 Cn = 1'b0;
    #1;
    n_tests++;
    if ({mag_on, cooking, tmr_en, tmr_load, tmr_clr_n} !== 5'b00001) begin
      n_fail++; $display("FAIL async_reset: mag/cook/en/load/clr_n=%b expected 00001", {mag_on, cooking, tmr_en, tmr_load, tmr_clr_n});
    end
    cyc();
    Cn = 1'b1; zero = 1'b1;
    cyc();
    n_tests++;
    if (tmr_clr_n !== 1'b0 || mag_on !== 1'b0) begin
      n_fail++; $display("FAIL reset_reclear: clr_n=%b mag=%b expected 0 0", tmr_clr_n, mag_on);
    end
    cyc();
    n_tests++;
    if (tmr_clr_n !== 1'b1) begin
      n_fail++; $display("FAIL reset_reclear_end: clr_n=%b expected 1", tmr_clr_n);
    end
  endtask

  initial begin
    test_reset();
    test_entry();
    test_cook_done(1'b0);
    test_cook_done(1'b1);
    test_pause(2);
    test_pause(int'($urandom_range(0, CLK_DIV - 1)));
    test_done_exit();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/mw_cook_controller.md
Name: mw_cook_controller

Overview:
- Control FSM for the microwave cook cycle. It acts as the initiator for the minutes/seconds countdown timer chain.
- Accepts keypad digits and shifts them into the timer through the timer load interface.
- Generates a one-second count-enable strobe while cooking, and reacts to the timer's zero flag.
- Drives the magnetron enable and the status outputs.

Parameters:
- CLK_DIV, 50000000, clock cycles per one-second tick; legal range 2..2^26.
- DONE_SECS, 3, seconds the DONE state is held before returning to IDLE; legal range 1..15.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- Cn  in  1  asynchronous active-low reset.
- key_valid  in  1  one-cycle strobe; a keypad digit is present.
- key_digit  in  4  BCD digit 0..9; values 10..15 are ignored.
- start  in  1  one-cycle strobe: start or resume cooking.
- stop  in  1  one-cycle strobe: pause, or clear when already paused or idle.
- door_closed  in  1  level; 1 = door closed.
- zero  in  1  level from timer; 1 = all timer digits are 0.
- tmr_in  out  4  digit presented to the timer load input.
- tmr_load  out  1  one-cycle load strobe to the timer (timer Cin).
- tmr_clr_n  out  1  active-low timer clear, one cycle long (timer Cn).
- tmr_en  out  1  one-cycle count-enable to the timer units stage, asserted once per second.
- mag_on  out  1  magnetron enable.
- cooking  out  1  status: FSM is in COOK.
- done  out  1  status: FSM is in DONE.

Behaviour:
- Reset (Cn=0, asynchronous): state=IDLE; tick counter=0; digit count=0.
  - All outputs are 0 except tmr_clr_n, which is 1.
  - The timer itself is cleared by a tmr_clr_n pulse issued in the first cycle after reset release.
- States: IDLE, ENTRY, COOK, PAUSE, DONE. All outputs are registered.
- IDLE:
  - A key_valid with a valid digit gives tmr_in=digit and tmr_load=1 in the next cycle, sets digit count to 1, and moves to ENTRY.
  - start with zero=1 is ignored.
- ENTRY:
  - Each valid key_valid loads one digit, 1 cycle latency.
  - Digits after the 3rd are ignored (digit count saturates at 3).
  - start with door_closed=1 and zero=0 moves to COOK and clears the tick counter.
  - start with door_closed=0 is ignored and the state stays ENTRY.
  - stop pulses tmr_clr_n=0 for 1 cycle, resets digit count, and moves to IDLE.
- COOK:
  - mag_on=1 and cooking=1.
  - The tick counter counts 0..CLK_DIV-1. At terminal count, tmr_en=1 for exactly 1 cycle and the counter wraps to 0.
  - zero=1 seen while tmr_en=0 moves to DONE in the next cycle; mag_on drops on that same edge.
  - door_closed=0 moves to PAUSE, with mag_on=0 on the next edge. The tick counter value is held.
  - stop moves to PAUSE.
  - Keypad input is ignored.
- PAUSE:
  - mag_on=0; the tick counter holds its value.
  - start with door_closed=1 moves back to COOK, resuming from the held tick count.
  - stop pulses tmr_clr_n and moves to IDLE.
- DONE:
  - done=1 for DONE_SECS ticks, then the FSM moves to IDLE.
  - start or stop moves to IDLE immediately.
  - A key_valid moves to ENTRY and loads that digit.
- Priority for simultaneous events in the same cycle, highest first: Cn, door open, stop, zero, start, key_valid.
- tmr_load, tmr_en and tmr_clr_n are never asserted in the same cycle. A load requested on a tick cycle cannot occur, because keys are ignored in COOK.
- Tick counter width is ceil(log2(CLK_DIV)). The DONE counter is 4 bits.

Optional Feature:
- Macro: MW_BEEP_EN.
- Defined:
  - Adds output beep (1 bit).
  - In DONE, beep toggles on every tick, starting at 1 on DONE entry. This gives an on/off pattern of DONE_SECS seconds.
  - beep=0 in all other states and on reset.
- Undefined: no beep port exists and DONE behaviour is otherwise identical.

Test Plan:
- Reset then key digits 1,3,0 -> three tmr_load pulses with tmr_in=1,3,0, each 1 cycle after its key_valid; state ENTRY.
- CLK_DIV=4: after entry, start with door closed -> mag_on=1 on the next edge; tmr_en pulses every 4 cycles. Force zero=1 -> done=1 and mag_on=0 on the next edge; IDLE after 3 ticks.
- During COOK, door_closed=0 at tick count 2 -> PAUSE with mag_on=0. Close the door and send start -> the first tmr_en arrives 2 cycles after re-entering COOK.
- In ENTRY send four digits 1,2,3,4 -> only 3 tmr_load pulses; the 4th digit produces no load.
- Same-cycle stop and start in COOK -> PAUSE. Then stop -> tmr_clr_n=0 for 1 cycle, then IDLE.
- Assert Cn=0 mid-COOK -> mag_on, cooking and tmr_en go to 0 asynchronously. With MW_BEEP_EN defined, beep toggles 1,0,1 over the DONE ticks.
